// File: rtl/rast_tri_arbiter.sv
// Round-robin front end that shares the rasterizer triangle input between two
// requesters, tracks end-of-frame and pulses frame_done_H once the hit stream goes quiet.
module rast_tri_arbiter #(
  parameter int SIGFIG       = 24,
  parameter int VERTS        = 3,
  parameter int AXIS         = 3,
  parameter int COLORS       = 3,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [1:0]                             req_en_RnnnnH,
  input  logic signed [VERTS*AXIS*SIGFIG-1:0]    req0_tri_S,
  input  logic [COLORS*SIGFIG-1:0]               req0_color_U,
  input  logic                                   req0_valid_H,
  input  logic                                   req0_last_H,
  output logic                                   req0_ready_H,
  input  logic signed [VERTS*AXIS*SIGFIG-1:0]    req1_tri_S,
  input  logic [COLORS*SIGFIG-1:0]               req1_color_U,
  input  logic                                   req1_valid_H,
  input  logic                                   req1_last_H,
  output logic                                   req1_ready_H,
  input  logic                                   halt_RnnnnL,
  output logic signed [VERTS*AXIS*SIGFIG-1:0]    tri_R10S,
  output logic [COLORS*SIGFIG-1:0]               color_R10U,
  output logic                                   validTri_R10H,
  input  logic                                   hit_valid_R18H,
  output logic                                   frame_done_H,
  output logic                                   busy_H
);

  localparam int TRI_W = VERTS * AXIS * SIGFIG;
  localparam int COL_W = COLORS * SIGFIG;
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TRI_W-1:0]    tri_q, tri_d;
  logic [COL_W-1:0]    color_q, color_d;
  logic                valid_q, valid_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [1:0]          done_q, done_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                frame_done_q, frame_done_d;

  logic [1:0]          req_valid;
  logic [1:0]          req_last;
  logic [1:0]          elig;
  logic [1:0]          win;
  logic [TRI_W-1:0]    req_tri   [2];
  logic [COL_W-1:0]    req_color [2];

  logic consume;
  logic slot_free;
  logic in_run;
  logic accept;
  logic win_sel;
  logic all_done;

  assign req_valid    = {req1_valid_H, req0_valid_H};
  assign req_last     = {req1_last_H, req0_last_H};
  assign req_tri[0]   = req0_tri_S;
  assign req_tri[1]   = req1_tri_S;
  assign req_color[0] = req0_color_U;
  assign req_color[1] = req1_color_U;

  assign consume   = valid_q & halt_RnnnnL;
  assign slot_free = ~valid_q | halt_RnnnnL;
  assign in_run    = (state_q == ST_RUN);

  // The pointer only breaks ties; a lone eligible requester always wins.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign elig[gi] = req_en_RnnnnH[gi] & req_valid[gi] & ~done_q[gi] & in_run & slot_free;
      assign win[gi]  = elig[gi] & (~elig[1-gi] | (rr_ptr_q == 1'(gi)));
    end
  endgenerate

  assign accept  = |win;
  assign win_sel = win[1];

  // Every enabled requester has finished and at least one actually sent a frame.
  assign all_done = (&(done_q | ~req_en_RnnnnH)) & (|req_en_RnnnnH) & (|done_q);

  always_comb begin
    tri_d        = tri_q;
    color_d      = color_q;
    valid_d      = valid_q;
    rr_ptr_d     = rr_ptr_q;
    done_d       = done_q | (win & req_last);
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    frame_done_d = 1'b0;

    if (accept) begin
      tri_d    = req_tri[win_sel];
      color_d  = req_color[win_sel];
      valid_d  = 1'b1;
      rr_ptr_d = ~win_sel;
    end else if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        // Looking at the next slot state lets DRAIN start right after the final consume.
        if (all_done && !valid_d) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (hit_valid_R18H) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == CNT_LAST) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
          drain_cnt_d  = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d     = ST_RUN;
        done_d      = '0;
        drain_cnt_d = '0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      tri_q        <= '0;
      color_q      <= '0;
      valid_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      done_q       <= '0;
      drain_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tri_q        <= tri_d;
      color_q      <= color_d;
      valid_q      <= valid_d;
      rr_ptr_q     <= rr_ptr_d;
      done_q       <= done_d;
      drain_cnt_q  <= drain_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign req0_ready_H  = win[0];
  assign req1_ready_H  = win[1];
  assign tri_R10S      = tri_q;
  assign color_R10U    = color_q;
  assign validTri_R10H = valid_q;
  assign frame_done_H  = frame_done_q;
  assign busy_H        = (state_q != ST_RUN) | valid_q | (|done_q);

endmodule

// File: tb/tb_rast_tri_arbiter.sv
// Randomized bench for rast_tri_arbiter: a frame-level reference model predicts readiness and
// issue order, and a monitor checks every issued triangle and frame_done pulse against it.
module tb_rast_tri_arbiter;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DC     = 16;
  localparam int TW     = VERTS * AXIS * SIGFIG;
  localparam int CW     = COLORS * SIGFIG;
  localparam int HIT_AT_LAST = 999;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           req_en;
  logic signed [TW-1:0] r0_tri, r1_tri;
  logic [CW-1:0]        r0_col, r1_col;
  logic                 r0_v, r1_v, r0_l, r1_l, r0_rdy, r1_rdy;
  logic                 halt, hit;
  logic signed [TW-1:0] tri_o;
  logic [CW-1:0]        col_o;
  logic                 vt, fd, busy;

  rast_tri_arbiter #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .req_en_RnnnnH(req_en),
    .req0_tri_S(r0_tri), .req0_color_U(r0_col), .req0_valid_H(r0_v), .req0_last_H(r0_l),
    .req0_ready_H(r0_rdy),
    .req1_tri_S(r1_tri), .req1_color_U(r1_col), .req1_valid_H(r1_v), .req1_last_H(r1_l),
    .req1_ready_H(r1_rdy),
    .halt_RnnnnL(halt), .tri_R10S(tri_o), .color_R10U(col_o), .validTri_R10H(vt),
    .hit_valid_R18H(hit), .frame_done_H(fd), .busy_H(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          src;
    logic [TW-1:0] t;
    logic [CW-1:0] c;
  } item_t;

  typedef struct packed {
    logic [1:0] en;
    int pv0; int pv1; int ph; int phit; int ln0; int ln1; int ncyc;
  } row_t;

  item_t exp_q[$];
  int    done_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  // Reference model state: frame phase 0 run, 1 waiting for quiet, 2 frame complete.
  bit       m_valid;
  bit [1:0] m_done;
  int       m_phase, m_streak, m_rr;
  int       m_fcnt[2];

  task automatic chk1(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", nm, cyc, act, req);
    end
  endtask

  task automatic chkw(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    bit [1:0] e;
    int       w;
    bit       all_done;
    if (!rst) begin
      m_valid = 1'b0; m_done = 2'b00; m_phase = 0; m_streak = 0; m_rr = 0;
      m_fcnt[0] = 0; m_fcnt[1] = 0;
      exp_q.delete();
      done_q.delete();
    end else begin
      chk1("validTri", vt, m_valid);
      chk1("busy", busy, (m_phase != 0) || m_valid || (m_done != 0));
      e[0] = req_en[0] && r0_v && !m_done[0] && m_phase == 0 && (!m_valid || halt);
      e[1] = req_en[1] && r1_v && !m_done[1] && m_phase == 0 && (!m_valid || halt);
      if (e == 2'b11) w = m_rr;
      else if (e[0])  w = 0;
      else if (e[1])  w = 1;
      else            w = -1;
      chk1("ready0", r0_rdy, w == 0);
      chk1("ready1", r1_rdy, w == 1);
      all_done = (m_done[0] || !req_en[0]) && (m_done[1] || !req_en[1]) &&
                 (req_en != 2'b00) && (m_done != 2'b00);
      if (w == 0) begin
        exp_q.push_back({1'b0, r0_tri, r0_col});
        m_fcnt[0]++;
        if (r0_l) m_done[0] = 1'b1;
      end else if (w == 1) begin
        exp_q.push_back({1'b1, r1_tri, r1_col});
        m_fcnt[1]++;
        if (r1_l) m_done[1] = 1'b1;
      end
      if (w >= 0) begin
        m_valid = 1'b1;
        m_rr    = 1 - w;
      end else if (m_valid && halt) begin
        m_valid = 1'b0;
      end
      case (m_phase)
        0: if (all_done && !m_valid) begin m_phase = 1; m_streak = 0; end
        1: begin
          m_streak = hit ? 0 : m_streak + 1;
          if (m_streak == DC) begin
            m_phase = 2;
            done_q.push_back(cyc + 1);
          end
        end
        default: begin
          m_phase = 0; m_done = 2'b00; m_streak = 0; m_fcnt[0] = 0; m_fcnt[1] = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    int ec;
    if (rst) begin
      if (vt) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL slot at cycle %0d: triangle presented, none expected", cyc);
        end else begin
          chkw("tri", tri_o, exp_q[0].t);
          chkw("color", TW'(col_o), TW'(exp_q[0].c));
          if (halt) begin
            $display("cycle %0d: issued triangle from requester %0d", cyc, exp_q[0].src);
            void'(exp_q.pop_front());
          end
        end
      end
      if (fd) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_done at cycle %0d: got 1 want 0", cyc);
        end else begin
          ec = done_q.pop_front();
          chki("frame_done_cycle", cyc, ec);
          $display("cycle %0d: frame done", cyc);
        end
      end
      if (done_q.size() > 0 && done_q[0] < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_done missing: got none want cycle %0d", done_q[0]);
        void'(done_q.pop_front());
      end
    end
  end

  function automatic logic last_of(input int ln, input int fcnt);
    if (ln == 0) return ($urandom_range(9) == 0);
    return (fcnt + 1 >= ln);
  endfunction

  task automatic drive(input row_t r, inout bit fired);
    @(posedge clk);
    #1;
    req_en = r.en;
    r0_v   = (int'($urandom_range(99)) < r.pv0);
    r1_v   = (int'($urandom_range(99)) < r.pv1);
    r0_l   = last_of(r.ln0, m_fcnt[0]);
    r1_l   = last_of(r.ln1, m_fcnt[1]);
    for (int i = 0; i < TW / 24; i++) begin
      r0_tri[i*24 +: 24] = 24'($urandom);
      r1_tri[i*24 +: 24] = 24'($urandom);
    end
    for (int i = 0; i < CW / 24; i++) begin
      r0_col[i*24 +: 24] = 24'($urandom);
      r1_col[i*24 +: 24] = 24'($urandom);
    end
    halt = (int'($urandom_range(99)) < r.ph);
    if (r.phit == HIT_AT_LAST) begin
      hit = !fired && m_phase == 1 && m_streak == DC - 1;
      if (hit) fired = 1'b1;
    end else begin
      hit = (int'($urandom_range(99)) < r.phit);
    end
  endtask

  row_t rows_a[$];
  row_t rows_b[$];

  initial begin
    bit fired;
    rst = 1'b0;
    req_en = 2'b00; r0_v = 0; r1_v = 0; r0_l = 0; r1_l = 0; halt = 0; hit = 0;
    r0_tri = '0; r1_tri = '0; r0_col = '0; r1_col = '0;
    #7;
    chk1("reset_validTri", vt, 1'b0);
    chk1("reset_frame_done", fd, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ready0", r0_rdy, 1'b0);
    chk1("reset_ready1", r1_rdy, 1'b0);
    chkw("reset_tri", tri_o, '0);
    chkw("reset_color", TW'(col_o), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    //                   en     pv0  pv1  ph   phit         ln0  ln1  ncyc
    rows_a.push_back(row_t'{2'b01, 100, 0,   100, 0,           5,   99,  40});
    rows_a.push_back(row_t'{2'b11, 100, 100, 100, 0,           8,   8,   60});
    rows_a.push_back(row_t'{2'b11, 100, 100, 100, 0,           99,  99,  3});
    rows_a.push_back(row_t'{2'b11, 100, 100, 0,   0,           99,  99,  7});
    rows_a.push_back(row_t'{2'b11, 100, 100, 100, 0,           1,   1,   30});
    rows_a.push_back(row_t'{2'b11, 100, 100, 100, 0,           2,   6,   60});
    rows_a.push_back(row_t'{2'b01, 100, 0,   100, HIT_AT_LAST, 3,   99,  45});
    rows_a.push_back(row_t'{2'b11, 70,  70,  80,  10,          0,   0,   150});
    rows_a.push_back(row_t'{2'b10, 0,   60,  70,  5,           0,   0,   100});
    rows_a.push_back(row_t'{2'b11, 50,  80,  60,  20,          0,   0,   150});
    rows_a.push_back(row_t'{2'b11, 100, 100, 100, 0,           99,  99,  4});
    rows_a.push_back(row_t'{2'b11, 100, 100, 0,   0,           99,  99,  3});
    rows_b.push_back(row_t'{2'b11, 100, 100, 100, 0,           3,   3,   40});
    rows_b.push_back(row_t'{2'b11, 0,   0,   100, 0,           0,   0,   40});

    foreach (rows_a[i]) begin
      fired = 1'b0;
      repeat (rows_a[i].ncyc) drive(rows_a[i], fired);
    end

    // Reset arrives while a triangle is held under halt.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk1("midreset_validTri", vt, 1'b0);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_frame_done", fd, 1'b0);
    chkw("midreset_tri", tri_o, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (rows_b[i]) begin
      fired = 1'b0;
      repeat (rows_b[i].ncyc) drive(rows_b[i], fired);
    end

    @(negedge clk);
    #1;
    chki("leftover_triangles", exp_q.size(), 0);
    chki("leftover_frame_done", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rast_tri_arbiter.md
# rast_tri_arbiter

Front-end scheduler that shares the single rasterizer triangle input (`tri_R10S`/`color_R10U`/`validTri_R10H`) between two triangle requesters, such as two scene streams or a driver plus a clear-pass generator. It applies round-robin arbitration, holds the issued triangle stable while the rasterizer halts, and tracks end-of-frame from both requesters. After the last triangle it watches the hit stream until the pipeline is quiet, then pulses `frame_done_H` so the z-buffer can be written out.

## Interface
Parameters:
- `SIGFIG`, 24, bits in position/color
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex
- `COLORS`, 3, color channels
- `DRAIN_CYCLES`, 16, consecutive hit-free cycles that declare the pipeline drained (≥ total pipe depth); counter width $clog2(DRAIN_CYCLES+1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `req_en_RnnnnH`  in  2  per-requester enable; static during a frame
- `reqN_tri_S` (N=0,1)  in  signed [SIGFIG-1:0] [VERTS][AXIS]  requester triangle
- `reqN_color_U`  in  unsigned [SIGFIG-1:0] [COLORS]  requester color
- `reqN_valid_H`  in  1  requester has a triangle
- `reqN_last_H`  in  1  qualifies the triangle as the last one of the frame
- `reqN_ready_H`  out  1  triangle accepted this cycle when high together with `reqN_valid_H`
- `halt_RnnnnL`  in  1  low means the rasterizer is not accepting
- `tri_R10S`, `color_R10U`, `validTri_R10H`  out  rasterizer input
- `hit_valid_R18H`  in  1  rasterizer output hit strobe
- `frame_done_H`  out  1  one-cycle pulse at frame completion
- `busy_H`  out  1  frame in progress

## Operation
- **Output slot:** one registered slot drives `tri_R10S`, `color_R10U` and `validTri_R10H`.
  - The slot is consumed when `validTri_R10H & halt_RnnnnL`.
  - The slot is free when `!validTri_R10H` or it is consumed this cycle.
- **Eligibility:** requester N is eligible when `req_en[N] & reqN_valid_H & !doneN`, the state is RUN and the slot is free.
- **Arbitration:**
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester selected by `rr_ptr` wins.
  - After each accept, `rr_ptr` points to the other requester.
  - `reqN_ready_H = winN`, which is combinational on `halt_RnnnnL`.
  - On accept the payload loads into the slot and `validTri` is set.
  - If the slot is consumed and nothing is accepted, `validTri` clears.
- **Halt:** while `halt_RnnnnL`=0, slot contents and `validTri_R10H` are held bit-exact. No new accept happens into a full slot.
- **Per-requester done flag:** `doneN` sets when a triangle accepted from requester N has `reqN_last_H`=1. Requester N then sees `ready`=0 until the frame ends.
- **FSM:**
  - **RUN:** arbitrate. Go to DRAIN when all of the following hold:
    - `(done0 | !req_en[0])`
    - `(done1 | !req_en[1])`
    - `req_en != 0`
    - at least one done flag is set
    - slot is empty
  - **DRAIN:** no accepts.
    - `drain_cnt` increments on cycles with `hit_valid_R18H`=0 and resets to 0 on a hit.
    - When `drain_cnt == DRAIN_CYCLES-1` with no hit, go to DONE.
  - **DONE:** `frame_done_H`=1 for exactly this cycle. Clear done flags and `drain_cnt`, then go to RUN.
- `busy_H` = (state≠RUN) | `validTri_R10H` | done0 | done1.

## Timing
- **Reset values:** all outputs 0, `tri_R10S`/`color_R10U` 0, state RUN, `rr_ptr`=0 (requester 0 has priority), done flags 0, `drain_cnt` 0.
- **Latency:** accept at edge k puts `validTri_R10H`=1 at k+1.
- **Throughput:** 1 triangle/cycle while `halt_RnnnnL`=1.
- **Last-triangle sequence:**
  - Last accept at edge k: slot valid from k+1.
  - Consumed at edge c: state DRAIN from c+1.
  - With no hits, `frame_done_H` is high in cycle c+1+DRAIN_CYCLES.
  - RUN resumes, with accepts possible, the next cycle.
- **Simultaneous events:**
  - If a hit arrives in the cycle the counter would expire, the counter resets and DONE does not occur.
  - A requester whose done flag is set never blocks the other requester's accepts.
- **Reset mid-frame:** asserting `rst` low at any point returns every state element to its reset value immediately (asynchronous). A held triangle is discarded.

## Test plan
- **Single requester:** `req_en`=01, 5 triangles back-to-back, last on the 5th, halt high → `validTri` on 5 consecutive cycles starting 1 cycle after the first accept; `frame_done_H` pulses once, 16 cycles after the 5th is consumed.
- **Fairness:** both requesters always valid, 8 triangles each → issue order 0,1,0,1,…; `ready` never high for both in the same cycle.
- **Halt:** triangle A in the slot, `halt_RnnnnL`=0 for 7 cycles → `tri_R10S`/`color_R10U` unchanged and both `ready` low. Halt release → A consumed, next triangle the following cycle.
- **Early last:** requester 0 sends last at triangle 2 while requester 1 sends 6 → requester 1 gets every slot after that; DRAIN only after requester 1's last is consumed.
- **Drain interrupted:** hit at DRAIN cycle 15 → counter restarts; `frame_done_H` 16 cycles after that hit.
- **Mid-frame reset:** `rst` low during a halted issue → `validTri_R10H`=0, `busy_H`=0 immediately; a new frame after release starts with requester 0 priority.
